// File: rtl/vga_frame_reader.sv
// Display-side reader for frame buffer 2: 640x480@60 VGA timing with a 2x-replicated
// 320x240 RGB444 fetch. All video outputs lag the raster counters by two clocks.
module vga_frame_reader #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int SRC_WIDTH = 320
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        enable_display,
    output logic [16:0] rdaddr_buf2,
    input  logic [11:0] din_buf2,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        vga_hsync,
    output logic        vga_vsync,
    output logic        vga_blank_n,
    output logic        frame_start,
    output logic        frame_done
);

    localparam logic [9:0]  H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0]  V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0]  H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0]  V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0]  HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0]  HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0]  VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [16:0] SRC_W    = 17'(SRC_WIDTH);

    typedef enum logic [1:0] {IDLE, WAIT_FRAME, ACTIVE} state_e;

    state_e      state_q;
    logic [9:0]  h_cnt_q, v_cnt_q, h_d, v_d;
    logic [8:0]  col_q, col_d;
    logic [16:0] row_q, row_d, rdaddr_d;
    logic        h_wrap, v_wrap, act0, act_d, disp_d, disp0;
    logic        hs0_n, vs0_n, fs0, fd0;
    logic [4:0]  pipe_q;  // {fd, fs, disp, vsync_n, hsync_n}

    assign h_wrap = (h_cnt_q == H_LAST);
    assign v_wrap = (v_cnt_q == V_LAST);
    assign act0   = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    assign disp0  = act0 && (state_q == ACTIVE);
    assign hs0_n  = !((h_cnt_q >= HS_START) && (h_cnt_q <= HS_END));
    assign vs0_n  = !((v_cnt_q >= VS_START) && (v_cnt_q <= VS_END));
    assign fs0    = disp0 && (h_cnt_q == '0) && (v_cnt_q == '0);
    assign fd0    = disp0 && (h_cnt_q == H_ACT - 10'd1) && (v_cnt_q == V_ACT - 10'd1);

    // The address register is loaded from next-state values so that rdaddr_buf2
    // lines up with the counters; the buffer's one-clock read fills stage 1.
    always_comb begin
        h_d = h_wrap ? '0 : h_cnt_q + 10'd1;
        v_d = v_cnt_q;
        if (h_wrap) v_d = v_wrap ? '0 : v_cnt_q + 10'd1;

        col_d = col_q;
        if (h_wrap)                    col_d = '0;
        else if (act0 && h_cnt_q[0])   col_d = col_q + 9'd1;

        row_d = row_q;
        if (h_wrap) begin
            if (v_wrap)                                 row_d = '0;
            else if ((v_cnt_q < V_ACT) && v_cnt_q[0])   row_d = row_q + SRC_W;
        end

        // ACTIVE->IDLE only happens where the next pixel is invisible, so only
        // the WAIT_FRAME->ACTIVE step has to be anticipated here.
        act_d  = (h_d < H_ACT) && (v_d < V_ACT);
        disp_d = act_d && ((state_q == ACTIVE) ||
                 ((state_q == WAIT_FRAME) && enable_display && h_wrap && v_wrap));
        rdaddr_d = disp_d ? row_q + 17'(col_d) : '0;
        if (disp_d) rdaddr_d = row_d + 17'(col_d);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE:       if (enable_display) state_q <= WAIT_FRAME;
                WAIT_FRAME: if (!enable_display)        state_q <= IDLE;
                            else if (h_wrap && v_wrap)  state_q <= ACTIVE;
                ACTIVE:     if (fd0 && !enable_display) state_q <= IDLE;
                default:    state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            h_cnt_q     <= '0;
            v_cnt_q     <= '0;
            col_q       <= '0;
            row_q       <= '0;
            rdaddr_buf2 <= '0;
            pipe_q      <= 5'b00011;
            vga_r       <= '0;
            vga_g       <= '0;
            vga_b       <= '0;
            vga_hsync   <= 1'b1;
            vga_vsync   <= 1'b1;
            vga_blank_n <= 1'b0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            h_cnt_q     <= h_d;
            v_cnt_q     <= v_d;
            col_q       <= col_d;
            row_q       <= row_d;
            rdaddr_buf2 <= rdaddr_d;
            pipe_q      <= {fd0, fs0, disp0, vs0_n, hs0_n};
            vga_hsync   <= pipe_q[0];
            vga_vsync   <= pipe_q[1];
            vga_blank_n <= pipe_q[2];
            frame_start <= pipe_q[3];
            frame_done  <= pipe_q[4];
            vga_r       <= pipe_q[2] ? din_buf2[11:8] : 4'h0;
            vga_g       <= pipe_q[2] ? din_buf2[7:4]  : 4'h0;
            vga_b       <= pipe_q[2] ? din_buf2[3:0]  : 4'h0;
        end
    end

endmodule

// File: doc/vga_frame_reader.md
Name: vga_frame_reader

Overview:
- Display-side reader of frame buffer 2, the consumer of the image that the grey/filter blocks write back into that buffer.
- Generates 640x480@60 VGA timing from the 25 MHz pixel clock.
- Fetches the 320x240 12-bit RGB444 frame (76800 words) with 2x pixel and line replication.
- Drives RGB and sync outputs with all outputs mutually aligned.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (clocks)
H_SYNC, 96, hsync pulse width (clocks)
H_BP, 48, horizontal back porch (clocks)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines)
SRC_WIDTH, 320, source line length in buffer words

Ports:
clk_i  in  1  25 MHz pixel clock
rst_i  in  1  asynchronous, active-low reset
enable_display  in  1  level; request display of buffer contents
rdaddr_buf2  out  17  frame buffer 2 read address, registered
din_buf2  in  12  buffer read data {R[11:8],G[7:4],B[3:0]}; valid 1 clock after rdaddr_buf2 is presented
vga_r  out  4  red
vga_g  out  4  green
vga_b  out  4  blue
vga_hsync  out  1  horizontal sync, active low
vga_vsync  out  1  vertical sync, active low
vga_blank_n  out  1  high during the visible region of a displayed frame
frame_start  out  1  one-clock pulse, aligned to the first visible pixel of a displayed frame
frame_done  out  1  one-clock pulse, aligned to the last visible pixel of a displayed frame

Behaviour:
- Reset (rst_i=0, async):
  - h_cnt=0, v_cnt=0, state=IDLE, rdaddr_buf2=0.
  - vga_r/g/b=0, vga_hsync=1, vga_vsync=1, vga_blank_n=0, frame_start=0, frame_done=0.
- Counters:
  - h_cnt is 10 bits and counts 0..799, then wraps.
  - v_cnt is 10 bits; it increments when h_cnt wraps and itself wraps 524->0.
  - Counters run in every state after reset release.
- Sync, measured at counter stage:
  - hsync low for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] = [656,751].
  - vsync low for v_cnt in [490,491].
  - active = (h_cnt<640 && v_cnt<480).
- Pipeline:
  - Stage0 is the counters. Stage1 registers rdaddr_buf2. din_buf2 is valid during stage2.
  - Outputs register at the end of stage2, so hsync, vsync, blank_n, rgb, frame_start and frame_done all lag the counters by exactly 2 clocks.
  - Sync/active flags are delayed through a 2-deep shift register.
- Address generation (no multiplier):
  - col_addr increments on odd h_cnt during active.
  - row_base is cleared at v_cnt=0 and adds SRC_WIDTH after each odd active line.
  - rdaddr_buf2 = row_base + (h_cnt>>1) while active and state=ACTIVE; otherwise it holds 0.
  - Range 0..76799; it never exceeds 76799.
- State machine:
  - IDLE: blank_n=0 and rgb=0; sync still toggles. Goes to WAIT_FRAME when enable_display=1.
  - WAIT_FRAME: goes to ACTIVE at h_cnt=0, v_cnt=0. Returns to IDLE if enable_display drops before then.
  - ACTIVE: rgb = din_buf2 fields when delayed active=1, else 0; blank_n = delayed active.
  - ACTIVE exit: at the end of the last visible pixel (h=639, v=479) it returns to IDLE if enable_display=0, else stays ACTIVE.
  - A mid-frame deassert never truncates the frame.
- frame_start is asserted in ACTIVE for the pixel at h=0, v=0 (delayed); frame_done for h=639, v=479 (delayed).
- Simultaneous events: an enable_display rise on the exact h=0, v=0 clock counts as WAIT_FRAME entry only; display starts at the next frame.
- Reset mid-operation takes effect immediately and asynchronously. Display restarts only through IDLE->WAIT_FRAME.

Test Plan:
1. Reset: hold rst_i=0 for 5 clocks with enable_display=1 -> all outputs at reset values; after release, first hsync low edge appears 658 clocks after reset release (656+2 pipeline).
2. Timing: free-run 2 frames -> hsync period 800 with low width 96; vsync period 420000 clocks with low width 1600; blank_n high for exactly 640x480 clocks per displayed frame.
3. Address sequence: enable before frame 0 -> line 0 h=0..5 gives rdaddr 0,0,1,1,2,2; line 1 repeats 0..319; line 2 starts at 320; last visible pixel reads 76799.
4. Data mapping: RAM model returns 12'hABC at address 5 -> vga_r=A, vga_g=B, vga_b=C on output pixels 10 and 11 of lines 0 and 1, coincident with blank_n=1.
5. Enable drop: deassert enable_display at v=200 -> frame completes through frame_done, next frame has blank_n=0 and rgb=0, and sync continues.
6. Async reset: assert rst_i at h=300, v=100 mid-display -> outputs reset in the same clock with no clock edge needed; after release with enable=1, display resumes at the next h=0, v=0 with frame_start.
